// File: rtl/uart_ctrl_pkg.sv
// Shared types and widths for the UART command controller.
package uart_ctrl_pkg;

    localparam int CMD_W  = 16;
    localparam int RESP_W = 8;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    typedef enum logic {
        REQ_ACK  = 1'b0,
        REQ_STAT = 1'b1
    } req_id_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO with registered occupancy.
// A push while full is dropped here; the caller is expected to hold it off.
module cmd_fifo
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Glue between the UART command wrapper and the core: buffers incoming
// commands, arbitrates two response sources onto one transmit path and
// flags a transmitter that never reports completion.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TO_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_rdy,
    input  logic [CMD_W-1:0]        cmd,
    output logic                    clr_cmd_rdy,
    output logic [CMD_W-1:0]        cmd_out,
    output logic                    cmd_vld,
    input  logic                    cmd_pop,
    output logic [$clog2(DEPTH):0]  cmd_cnt,
    input  logic                    ack_req,
    input  logic [RESP_W-1:0]       ack_byte,
    output logic                    ack_busy,
    input  logic                    stat_req,
    input  logic [RESP_W-1:0]       stat_byte,
    output logic                    stat_busy,
    output logic                    send_resp,
    output logic [RESP_W-1:0]       resp,
    input  logic                    resp_sent,
    output logic                    tx_err
);

    localparam int TW = $clog2(TO_CYCLES + 1);

    logic              fifo_full;
    logic              fifo_empty;

    tx_state_t         state_q, state_d;
    logic              ack_busy_q, ack_busy_d;
    logic [RESP_W-1:0] ack_byte_q, ack_byte_d;
    logic              stat_busy_q, stat_busy_d;
    logic [RESP_W-1:0] stat_byte_q, stat_byte_d;
    req_id_t           last_q, last_d;
    req_id_t           gnt_q, gnt_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              err_q, err_d;
    logic              tx_done;

    // Accepting a command is decided on registered occupancy, so a pop while
    // full only frees the slot for the following cycle. Gating with rst_n keeps
    // the acknowledge low for the whole time reset is held.
    assign clr_cmd_rdy = cmd_rdy & ~fifo_full & rst_n;
    assign cmd_vld     = ~fifo_empty;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (clr_cmd_rdy),
        .data_i  (cmd),
        .pop_i   (cmd_pop),
        .head_o  (cmd_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (cmd_cnt)
    );

    assign send_resp = (state_q == TX_SEND);
    assign resp      = resp_q;
    assign ack_busy  = ack_busy_q;
    assign stat_busy = stat_busy_q;
    assign tx_err    = err_q;

    // Request capture, round-robin grant, transmit handshake and timeout.
    always_comb begin
        state_d     = state_q;
        ack_busy_d  = ack_busy_q;
        ack_byte_d  = ack_byte_q;
        stat_busy_d = stat_busy_q;
        stat_byte_d = stat_byte_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        resp_d      = resp_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        tx_done     = 1'b0;

        if (ack_req && !ack_busy_q) begin
            ack_busy_d = 1'b1;
            ack_byte_d = ack_byte;
        end
        if (stat_req && !stat_busy_q) begin
            stat_busy_d = 1'b1;
            stat_byte_d = stat_byte;
        end

        case (state_q)
            TX_IDLE: begin
                if (ack_busy_q && (!stat_busy_q || last_q == REQ_STAT)) begin
                    gnt_d   = REQ_ACK;
                    last_d  = REQ_ACK;
                    resp_d  = ack_byte_q;
                    state_d = TX_SEND;
                end else if (stat_busy_q) begin
                    gnt_d   = REQ_STAT;
                    last_d  = REQ_STAT;
                    resp_d  = stat_byte_q;
                    state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tmr_d   = '0;
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (resp_sent) begin
                    tx_done = 1'b1;
                end else if (tmr_q == TW'(TO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    tx_done = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (tx_done) begin
            state_d = TX_IDLE;
            if (gnt_q == REQ_ACK) begin
                ack_busy_d = 1'b0;
            end else begin
                stat_busy_d = 1'b0;
            end
        end
    end

    // Controller state registers; last grant resets to STAT so ACK wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            ack_busy_q  <= 1'b0;
            ack_byte_q  <= '0;
            stat_busy_q <= 1'b0;
            stat_byte_q <= '0;
            last_q      <= REQ_STAT;
            gnt_q       <= REQ_ACK;
            resp_q      <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_busy_q  <= ack_busy_d;
            ack_byte_q  <= ack_byte_d;
            stat_busy_q <= stat_busy_d;
            stat_byte_q <= stat_byte_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            resp_q      <= resp_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model and scoreboards.
module tb_uart_cmd_ctrl;

    localparam int DEPTH     = 4;
    localparam int TO_CYCLES = 8;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_rdy = 1'b0;
    logic [15:0]   cmd = '0;
    logic          clr_cmd_rdy;
    logic [15:0]   cmd_out;
    logic          cmd_vld;
    logic          cmd_pop = 1'b0;
    logic [CW-1:0] cmd_cnt;
    logic          ack_req = 1'b0;
    logic [7:0]    ack_byte = '0;
    logic          ack_busy;
    logic          stat_req = 1'b0;
    logic [7:0]    stat_byte = '0;
    logic          stat_busy;
    logic          send_resp;
    logic [7:0]    resp;
    logic          resp_sent = 1'b0;
    logic          tx_err;

    int total = 0;
    int bad   = 0;

    // Reference model state (owned by the monitor)
    logic [15:0] cmdModel[$];
    logic [7:0]  respQ[$];
    logic [7:0]  sentLog[$];
    bit          mAckBusy, mStatBusy, mErr, mLastStat, mGntStat;
    logic [7:0]  mAckByte, mStatByte;
    int          mPhase, mWait;
    bit          nAck, nStat, mDone, mFull;
    int          acceptCnt = 0;
    int          delaySeq = 0;
    int          pendingDelay = 0;

    // Stimulus knobs and wrapper emulation (owned by the driver)
    logic [15:0] cmdSendQ[$];
    int          acceptSeen = 0;
    int          delaySeen = 0;
    int          countdown = 0;
    int          respDelay = 2;
    bit          randomResp = 1'b0;
    bit          spurOn = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .DEPTH     (DEPTH),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_out     (cmd_out),
        .cmd_vld     (cmd_vld),
        .cmd_pop     (cmd_pop),
        .cmd_cnt     (cmd_cnt),
        .ack_req     (ack_req),
        .ack_byte    (ack_byte),
        .ack_busy    (ack_busy),
        .stat_req    (stat_req),
        .stat_byte   (stat_byte),
        .stat_busy   (stat_busy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .tx_err      (tx_err)
    );

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        cmdModel.delete();
        respQ.delete();
        mAckBusy  = 0;
        mStatBusy = 0;
        mErr      = 0;
        mLastStat = 1;
        mGntStat  = 0;
        mAckByte  = '0;
        mStatByte = '0;
        mPhase    = 0;
        mWait     = 0;
    endtask

    // Monitor: compares DUT outputs with the model mid-cycle, then advances
    // the model by the inputs that the coming clock edge will see.
    always @(negedge clk) begin
        if (!rst_n) begin
            resetModel();
        end else begin
            checkOutput("cmd_cnt", 32'(cmd_cnt), 32'(cmdModel.size()));
            checkOutput("cmd_vld", 32'(cmd_vld), 32'(cmdModel.size() != 0));
            if (cmdModel.size() != 0) checkOutput("cmd_out", 32'(cmd_out), 32'(cmdModel[0]));
            checkOutput("clr_cmd_rdy", 32'(clr_cmd_rdy), 32'(cmd_rdy && cmdModel.size() < DEPTH));
            checkOutput("send_resp", 32'(send_resp), 32'(mPhase == 1));
            checkOutput("ack_busy", 32'(ack_busy), 32'(mAckBusy));
            checkOutput("stat_busy", 32'(stat_busy), 32'(mStatBusy));
            checkOutput("tx_err", 32'(tx_err), 32'(mErr));
            if (send_resp) begin
                sentLog.push_back(resp);
                if (respQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL resp_strobe: got byte %0h, want no strobe", resp);
                end else begin
                    checkOutput("resp", 32'(resp), 32'(respQ.pop_front()));
                end
                pendingDelay = randomResp ? int'($urandom_range(1, 10)) : respDelay;
                delaySeq++;
            end

            // Command path: pop then push keeps order right when both happen.
            mFull = (cmdModel.size() == DEPTH);
            if (cmd_pop && cmdModel.size() != 0) void'(cmdModel.pop_front());
            if (cmd_rdy && !mFull) begin
                cmdModel.push_back(cmd);
                acceptCnt++;
            end

            // Response path
            nAck  = mAckBusy;
            nStat = mStatBusy;
            mDone = 0;
            if (ack_req && !mAckBusy) begin
                nAck = 1;
                mAckByte = ack_byte;
            end
            if (stat_req && !mStatBusy) begin
                nStat = 1;
                mStatByte = stat_byte;
            end
            if (mPhase == 0) begin
                if (mAckBusy && (!mStatBusy || mLastStat)) begin
                    mGntStat = 0; mLastStat = 0; mPhase = 1;
                    respQ.push_back(mAckByte);
                end else if (mStatBusy) begin
                    mGntStat = 1; mLastStat = 1; mPhase = 1;
                    respQ.push_back(mStatByte);
                end
            end else if (mPhase == 1) begin
                mPhase = 2;
                mWait  = 0;
            end else begin
                mWait++;
                if (resp_sent) mDone = 1;
                else if (mWait == TO_CYCLES) begin
                    mErr  = 1;
                    mDone = 1;
                end
            end
            if (mDone) begin
                if (mGntStat) nStat = 0;
                else nAck = 0;
                mPhase = 0;
            end
            mAckBusy  = nAck;
            mStatBusy = nStat;
        end
    end

    // Advance one cycle: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cmd_pop  = 0;
        ack_req  = 0;
        stat_req = 0;
        if (acceptCnt != acceptSeen) begin
            acceptSeen = acceptCnt;
            cmd_rdy = 0;
        end else if (!cmd_rdy && cmdSendQ.size() > 0) begin
            cmd_rdy = 1;
            cmd = cmdSendQ.pop_front();
        end
        if (delaySeq != delaySeen) begin
            delaySeen = delaySeq;
            countdown = pendingDelay;
        end
        resp_sent = 0;
        if (countdown == 1) resp_sent = 1;
        else if (spurOn && ($urandom % 30 == 0)) resp_sent = 1;
        if (countdown > 0) countdown--;
    endtask

    task automatic applyStimulus(int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (cmdSendQ.size() < 2 && ($urandom % 100) < 30) cmdSendQ.push_back(16'($urandom));
            cmd_pop   = (($urandom % 100) < 35);
            ack_req   = (($urandom % 100) < 10);
            ack_byte  = 8'($urandom);
            stat_req  = (($urandom % 100) < 10);
            stat_byte = 8'($urandom);
        end
    endtask

    task automatic doReset(bit holdCmdRdy);
        rst_n = 0;
        cmd_rdy = holdCmdRdy;
        cmd_pop = 0; ack_req = 0; stat_req = 0; resp_sent = 0;
        countdown = 0;
        #1;
        checkOutput("rst_send_resp", 32'(send_resp), 0);
        checkOutput("rst_clr_cmd_rdy", 32'(clr_cmd_rdy), 0);
        checkOutput("rst_cmd_vld", 32'(cmd_vld), 0);
        checkOutput("rst_cmd_cnt", 32'(cmd_cnt), 0);
        checkOutput("rst_cmd_out", 32'(cmd_out), 0);
        checkOutput("rst_ack_busy", 32'(ack_busy), 0);
        checkOutput("rst_stat_busy", 32'(stat_busy), 0);
        checkOutput("rst_tx_err", 32'(tx_err), 0);
        checkOutput("rst_resp", 32'(resp), 0);
        cmd_rdy = 0;
        cmdSendQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        acceptSeen = acceptCnt;
        delaySeen  = delaySeq;
    endtask

    task automatic checkLog(string name, int start, logic [7:0] exp[$]);
        checkOutput({name, "_count"}, 32'(sentLog.size() - start), 32'(exp.size()));
        for (int i = 0; i < exp.size() && start + i < sentLog.size(); i++)
            checkOutput(name, 32'(sentLog[start + i]), 32'(exp[i]));
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios, random traffic, drain and summary.
    initial begin
        int logStart;
        logic [15:0] ord[4];
        ord = '{16'h0002, 16'h0003, 16'h0004, 16'h0005};

        repeat (2) @(posedge clk);
        #1;
        doReset(1'b0);

        // Single command round trip
        cmdSendQ.push_back(16'hA55A);
        tick();
        tick();
        checkOutput("single_cnt", 32'(cmd_cnt), 1);
        checkOutput("single_out", 32'(cmd_out), 32'h0000A55A);
        cmd_pop = 1;
        tick();
        checkOutput("single_cnt_after_pop", 32'(cmd_cnt), 0);

        // Fill, backpressure, then drain in order
        for (int i = 1; i <= 5; i++) cmdSendQ.push_back(16'(i));
        repeat (14) tick();
        checkOutput("full_cnt", 32'(cmd_cnt), DEPTH);
        checkOutput("full_no_clr", 32'(clr_cmd_rdy), 0);
        cmd_pop = 1;
        tick();
        checkOutput("after_pop_cnt", 32'(cmd_cnt), 3);
        checkOutput("after_pop_clr", 32'(clr_cmd_rdy), 1);
        tick();
        checkOutput("refill_cnt", 32'(cmd_cnt), DEPTH);
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill_order", 32'(cmd_out), 32'(ord[i]));
            cmd_pop = 1;
            tick();
        end
        checkOutput("drained_cnt", 32'(cmd_cnt), 0);

        // Simultaneous requests alternate
        respDelay = 2;
        logStart = sentLog.size();
        ack_req = 1; ack_byte = 8'h3C; stat_req = 1; stat_byte = 8'hC3;
        repeat (12) tick();
        ack_req = 1; ack_byte = 8'h5A; stat_req = 1; stat_byte = 8'hA5;
        repeat (12) tick();
        checkLog("arb_order", logStart, '{8'h3C, 8'hC3, 8'h5A, 8'hA5});

        // Second request while busy is ignored
        logStart = sentLog.size();
        ack_req = 1; ack_byte = 8'h11;
        tick();
        ack_req = 1; ack_byte = 8'h22;
        repeat (8) tick();
        checkLog("dup_ignored", logStart, '{8'h11});

        // Timeout sets the sticky error eight cycles after entering the wait
        respDelay = 0;
        logStart = sentLog.size();
        ack_req = 1; ack_byte = 8'h77;
        repeat (10) tick();
        checkOutput("to_not_yet", 32'(tx_err), 0);
        tick();
        checkOutput("to_err", 32'(tx_err), 1);
        checkOutput("to_ack_busy", 32'(ack_busy), 0);
        respDelay = 1;
        stat_req = 1; stat_byte = 8'h42;
        repeat (8) tick();
        checkLog("after_timeout", logStart, '{8'h77, 8'h42});
        checkOutput("to_err_sticky", 32'(tx_err), 1);

        // Completion on the expiry cycle is a success
        doReset(1'b0);
        respDelay = 8;
        logStart = sentLog.size();
        ack_req = 1; ack_byte = 8'h99;
        repeat (14) tick();
        checkOutput("expiry_no_err", 32'(tx_err), 0);
        checkOutput("expiry_ack_busy", 32'(ack_busy), 0);
        checkLog("expiry_log", logStart, '{8'h99});

        // Reset while waiting with commands queued
        respDelay = 0;
        cmdSendQ.push_back(16'h1111);
        cmdSendQ.push_back(16'h2222);
        ack_req = 1; ack_byte = 8'h5C;
        repeat (6) tick();
        checkOutput("pre_reset_cnt", 32'(cmd_cnt), 2);
        doReset(1'b1);

        // Random traffic with one reset in the middle
        randomResp = 1;
        spurOn = 1;
        applyStimulus(1500);
        doReset(1'b0);
        applyStimulus(1500);

        // Drain everything out
        randomResp = 0;
        spurOn = 0;
        respDelay = 1;
        for (int c = 0; c < 60; c++) begin
            tick();
            cmd_pop = 1;
        end
        tick();
        checkOutput("final_resp_queue", 32'(respQ.size()), 0);
        checkOutput("final_cmd_cnt", 32'(cmd_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
